// File: rtl/coin_spawner.sv
// coin_spawner: launches coins per lane, judges hits/misses, keeps score and lives.
// Optional spawn speedup every 8 hits: define COIN_SPAWNER_SPEEDUP_EN.
module coin_spawner #(
    parameter int          LANES       = 3,
    parameter int          START_LIVES = 3,
    parameter int          MIN_GAP     = 12,
    parameter int          HIT_FRAMES  = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_v_sync,
    input  logic             i_start,
    input  logic [LANES-1:0] i_lane_btn,
    input  logic [LANES-1:0] i_in_position,
    output logic [LANES-1:0] o_active,
    output logic [15:0]      o_score,
    output logic [2:0]       o_lives,
    output logic             o_game_over,
    output logic             o_hit_pulse,
    output logic             o_miss_pulse
);
    localparam int GW = $clog2(MIN_GAP + 16) + 1;
    localparam int WW = $clog2(HIT_FRAMES + 1);
    localparam int CW = $clog2(LANES + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;
    typedef enum logic [1:0] {L_IDLE, L_TRAVEL, L_WINDOW} lane_t;

    state_t          r_state;
    state_t          w_state_nxt;
    lane_t           r_lane     [LANES];
    lane_t           w_lane_nxt [LANES];
    logic [WW-1:0]   r_win      [LANES];
    logic [WW-1:0]   w_win_nxt  [LANES];
    logic            r_vs1, r_vs2, r_vs3;
    logic [LANES-1:0] r_btn;
    logic [15:0]     r_lfsr;
    logic [GW-1:0]   r_gap;
    logic [15:0]     r_score;
    logic [2:0]      r_lives;
    logic            r_hit_pulse, r_miss_pulse;

    logic            w_tick, w_run, w_start, w_spawn, w_over;
    logic [LANES-1:0] w_btn_rise, w_hits, w_misses;
    logic [15:0]     w_lfsr_nxt;
    logic [1:0]      w_sel;
    logic [GW-1:0]   w_base, w_gap_rld;
    logic [CW-1:0]   w_nhit, w_nmiss;
    logic [2:0]      w_lives_nxt;
    logic [16:0]     w_score_sum;
    logic [15:0]     w_score_nxt;

    assign w_tick      = r_vs2 & ~r_vs3;
    assign w_btn_rise  = i_lane_btn & ~r_btn;
    assign w_run       = (r_state == S_RUN);
    assign w_start     = ~w_run & i_start;
    assign w_lfsr_nxt  = {r_lfsr[14:0],
                          r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_sel       = (w_lfsr_nxt[1:0] == 2'd3) ? 2'd1 : w_lfsr_nxt[1:0];
    assign w_spawn     = w_run & w_tick & (r_gap <= GW'(1));
    assign w_gap_rld   = w_base + GW'(w_lfsr_nxt[5:2]);
    assign w_lives_nxt = (r_lives > 3'(w_nmiss)) ? r_lives - 3'(w_nmiss) : 3'd0;
    assign w_score_sum = {1'b0, r_score} + 17'(w_nhit);
    assign w_score_nxt = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
    assign w_over      = w_run & (w_lives_nxt == 3'd0);

`ifdef COIN_SPAWNER_SPEEDUP_EN
    logic [2:0]    r_hcnt;
    logic [GW-1:0] r_base;
    logic [3:0]    w_hsum;

    assign w_hsum = {1'b0, r_hcnt} + 4'(w_nhit);
    assign w_base = r_base;

    // Every wrap of the hit counter shortens the spawn gap base by two, floor four.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || w_start) begin
            r_hcnt <= '0;
            r_base <= GW'(MIN_GAP);
        end else if (w_run) begin
            r_hcnt <= w_hsum[2:0];
            if (w_hsum[3])
                r_base <= (r_base > GW'(5)) ? r_base - GW'(2) : GW'(4);
        end
    end
`else
    assign w_base = GW'(MIN_GAP);
`endif

    // Per-lane launch, window entry and hit/miss judgement for this clock.
    always_comb begin
        w_hits   = '0;
        w_misses = '0;
        for (int i = 0; i < LANES; i++) begin
            w_lane_nxt[i] = r_lane[i];
            w_win_nxt[i]  = r_win[i];
            if (w_run) begin
                case (r_lane[i])
                    L_IDLE: begin
                        if (w_spawn && (w_sel == 2'(i)))
                            w_lane_nxt[i] = L_TRAVEL;
                    end
                    L_TRAVEL: begin
                        if (i_in_position[i]) begin
                            w_lane_nxt[i] = L_WINDOW;
                            w_win_nxt[i]  = WW'(HIT_FRAMES);
                        end
                    end
                    L_WINDOW: begin
                        if (w_btn_rise[i]) begin
                            w_hits[i]     = 1'b1;
                            w_lane_nxt[i] = L_IDLE;
                        end else if (!i_in_position[i]) begin
                            w_misses[i]   = 1'b1;
                            w_lane_nxt[i] = L_IDLE;
                        end else if (w_tick) begin
                            w_win_nxt[i] = r_win[i] - WW'(1);
                            if (r_win[i] == WW'(1)) begin
                                w_misses[i]   = 1'b1;
                                w_lane_nxt[i] = L_IDLE;
                            end
                        end
                    end
                    default: w_lane_nxt[i] = L_IDLE;
                endcase
            end
        end
    end

    // Count this clock's hits and misses across lanes.
    always_comb begin
        w_nhit  = '0;
        w_nmiss = '0;
        for (int i = 0; i < LANES; i++) begin
            w_nhit  = w_nhit + CW'(w_hits[i]);
            w_nmiss = w_nmiss + CW'(w_misses[i]);
        end
    end

    // Global game state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Global game next-state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_over)  w_state_nxt = S_OVER;
            S_OVER:  if (i_start) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from game and lane state.
    always_comb begin
        o_game_over = (r_state == S_OVER);
        for (int i = 0; i < LANES; i++)
            o_active[i] = (r_lane[i] != L_IDLE);
    end

    assign o_score      = r_score;
    assign o_lives      = r_lives;
    assign o_hit_pulse  = r_hit_pulse;
    assign o_miss_pulse = r_miss_pulse;

    // Sync/edge pipes, LFSR, spawn gap, score, lives and lane state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_vs1        <= 1'b0;
            r_vs2        <= 1'b0;
            r_vs3        <= 1'b0;
            r_btn        <= '0;
            r_lfsr       <= LFSR_SEED;
            r_gap        <= GW'(MIN_GAP);
            r_score      <= '0;
            r_lives      <= 3'(START_LIVES);
            r_hit_pulse  <= 1'b0;
            r_miss_pulse <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_lane[i] <= L_IDLE;
                r_win[i]  <= '0;
            end
        end else begin
            r_vs1        <= i_v_sync;
            r_vs2        <= r_vs1;
            r_vs3        <= r_vs2;
            r_btn        <= i_lane_btn;
            r_hit_pulse  <= |w_hits;
            r_miss_pulse <= |w_misses;
            if (w_start) begin
                r_lfsr  <= LFSR_SEED;
                r_gap   <= GW'(MIN_GAP);
                r_score <= '0;
                r_lives <= 3'(START_LIVES);
                for (int i = 0; i < LANES; i++)
                    r_lane[i] <= L_IDLE;
            end else if (w_run) begin
                r_score <= w_score_nxt;
                r_lives <= w_lives_nxt;
                if (w_tick) begin
                    r_lfsr <= w_lfsr_nxt;
                    r_gap  <= w_spawn ? w_gap_rld : r_gap - GW'(1);
                end
                for (int i = 0; i < LANES; i++) begin
                    r_lane[i] <= w_over ? L_IDLE : w_lane_nxt[i];
                    r_win[i]  <= w_win_nxt[i];
                end
            end
        end
    end
endmodule

// File: doc/coin_spawner.md
Name: coin_spawner

Overview:
- Game-control stage directly upstream of the per-lane coin sprite renderers (left/centre/right).
- Decides when each lane's coin is launched by driving that lane's `active` input.
- Consumes each sprite's `in_position` output and the player's lane buttons, and judges hit or miss.
- Maintains score, lives and game-over state, and feeds them to the HUD and audio blocks.

Parameters:
- LANES, 3, number of coin lanes; bit 0 = left, 1 = centre, 2 = right.
- START_LIVES, 3, lives loaded on game start (1..7).
- MIN_GAP, 12, minimum frames between spawn attempts.
- HIT_FRAMES, 8, maximum frames a lane's hit window stays open after `in_position` rises.
- LFSR_SEED, 16'hACE1, LFSR value loaded on reset and on game start; must be non-zero.

Ports:
- i_clk  in  1  pixel clock; all state updates on its rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_v_sync  in  1  vertical sync from the timing generator; rising edge = frame tick.
- i_start  in  1  level; starts a game from IDLE or OVER.
- i_lane_btn  in  LANES  raw player lane buttons, level, already debounced.
- i_in_position  in  LANES  per-lane `in_position` from the coin sprites.
- o_active  out  LANES  per-lane `active` to the coin sprites.
- o_score  out  16  hit count, saturating.
- o_lives  out  3  remaining lives.
- o_game_over  out  1  high in OVER.
- o_hit_pulse  out  1  one-clock pulse per judged hit.
- o_miss_pulse  out  1  one-clock pulse per judged miss.

Behaviour:
- **Frame tick:** `i_v_sync` registered twice.
  - frame_tick = rising edge of the second stage.
  - Tick latency is 2–3 clocks after the `i_v_sync` rise.
- **Button edges:** `i_lane_btn` registered once; btn_rise = current & ~previous, per lane, evaluated every clock.
- **Reset (i_rst_n=0 at a clock edge):**
  - State IDLE; o_active=0, o_score=0, o_lives=START_LIVES, o_game_over=0, pulses=0.
  - LFSR=LFSR_SEED; gap counter=MIN_GAP; all lanes L_IDLE.
  - Applies mid-game: all coins are dropped the same clock.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11, shifts once per frame_tick in RUN only.
- **Global FSM:**
  - IDLE -> RUN on i_start=1. Loads o_score=0, o_lives=START_LIVES, LFSR=LFSR_SEED, gap=MIN_GAP.
  - RUN -> OVER when o_lives reaches 0. All o_active drop to 0 on the same clock.
  - OVER -> RUN on i_start=1, with the same loads as IDLE -> RUN.
- **Spawn (RUN, per frame_tick):**
  - Gap counter decrements.
  - At 0: lane = LFSR[1:0], with value 3 mapped to lane 1.
  - If that lane is L_IDLE, it goes to L_TRAVEL and o_active[lane]=1. Otherwise the attempt is skipped, with no retry.
  - Gap reloads with MIN_GAP + LFSR[5:2] (range MIN_GAP..MIN_GAP+15).
- **Per-lane FSM (RUN only):**
  - L_IDLE: o_active=0. Leaves only on spawn.
  - L_TRAVEL: o_active=1. Goes to L_WINDOW on i_in_position=1; the window counter loads HIT_FRAMES.
  - L_WINDOW: o_active=1.
    - btn_rise on this lane -> hit: score+1 (saturate at 16'hFFFF), o_hit_pulse, lane -> L_IDLE.
    - Otherwise, window counter decrements per frame_tick. Reaching 0, or i_in_position falling, -> miss: lives−1, o_miss_pulse, lane -> L_IDLE.
    - A hit and a miss condition on the same clock: the hit wins.
  - btn_rise on a lane not in L_WINDOW is ignored.
- **Multiple judgements in one clock:**
  - Lives decrement by the number of misses, saturating at 0.
  - Score increments by the number of hits.
  - Pulses are single-cycle regardless of count.
- **Inputs outside RUN:** i_start in RUN is ignored. i_lane_btn and i_in_position are ignored outside RUN.

Optional Feature:
- Macro: COIN_SPAWNER_SPEEDUP_EN.
- When defined:
  - A 3-bit hit counter wraps every 8 hits.
  - Each wrap reduces the effective MIN_GAP by 2, floored at 4.
  - The effective gap resets to MIN_GAP on game start.
- When undefined: gap base is always MIN_GAP; no speedup logic is synthesised.

Test Plan:
- **Reset/IDLE:** Hold i_rst_n=0 for 3 clocks, release, and run 40 v_sync frames with no i_start. Required: o_active=000, o_lives=3, o_score=0, o_game_over=0.
- **First spawn:** Pulse i_start, then 12 frame ticks. Required: exactly one o_active bit set; lane equals the LFSR_SEED-derived mapping after 12 shifts, matching the reference model.
- **Hit:**
  - Drive i_in_position on the active lane, then press its button 2 frames later.
  - Required: o_hit_pulse for 1 clock, o_score=1, o_active bit clears next clock, o_lives=3.
  - Hold the button high afterwards: no second hit.
- **Timeout miss:** i_in_position held high with no button. Required: o_miss_pulse exactly after frame tick 8 of the window; o_lives=2.
- **Early-drop miss, then game over:**
  - Fall of i_in_position at window frame 3 -> miss.
  - Three misses total -> o_lives=0, o_game_over=1, o_active=000.
  - i_start -> RUN with o_score=0, o_lives=3.
- **Simultaneous events, then mid-game reset:**
  - Button edge and window expiry on the same clock -> hit counted, no miss.
  - Two lanes miss on the same clock with lives=2 -> o_lives=0, OVER.
  - i_rst_n=0 mid-RUN -> all outputs at reset values next clock.
